// File: rtl/edge_detect_multi_if.sv
// Channel-vector bundle for edge_detect_multi: raw inputs with per-channel mode and clear,
// plus the filtered level, edge pulses, sticky flags and aggregate interrupt.
interface edge_detect_multi_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0]   din;
  logic [2*CHANNELS-1:0] mode;
  logic [CHANNELS-1:0]   clr;
  logic [CHANNELS-1:0]   pulse;
  logic [CHANNELS-1:0]   level;
  logic [CHANNELS-1:0]   sticky;
  logic                  irq;

  modport master (output din, mode, clr, input pulse, level, sticky, irq);
  modport slave  (input din, mode, clr, output pulse, level, sticky, irq);
endinterface

// File: rtl/edge_detect_multi.sv
// Multi-channel synchronised, glitch-filtered edge detector with sticky W1C flags and irq.
// Latency din->pulse is SYNC_STAGES+FILTER_LEN-1 edges after din is sampled; no backpressure.
module edge_detect_multi #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input logic               clk,
  input logic               reset,
  edge_detect_multi_if.slave bus
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FILTER_LEN - 1);
  localparam bit SINGLE = (FILTER_LEN == 1);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_RISE_PEND = 2'd1,
    S_HIGH      = 2'd2,
    S_FALL_PEND = 2'd3
  } state_t;

  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("edge_detect_multi: CHANNELS must be 1..32");
  end
  if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("edge_detect_multi: SYNC_STAGES must be 0..3");
  end
  if (FILTER_LEN < 1 || FILTER_LEN > 255) begin : g_bad_filter
    $error("edge_detect_multi: FILTER_LEN must be 1..255");
  end

  logic [CHANNELS-1:0] ds;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign ds = bus.din;
  end else begin : g_sync
    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
        sync_q[0] <= bus.din;
        for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
    end

    assign ds = sync_q[SYNC_STAGES-1];
  end

  state_t              state_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_q   [CHANNELS];
  logic [CHANNELS-1:0] level_q;
  logic [CHANNELS-1:0] pulse_q;
  logic [CHANNELS-1:0] sticky_q;

  logic [CHANNELS-1:0] acc_rise;
  logic [CHANNELS-1:0] acc_fall;
  logic [CHANNELS-1:0] fire;

  // Acceptance happens on the sample that completes the filter run; mode is only looked at here.
  always_comb begin
    acc_rise = '0;
    acc_fall = '0;
    fire     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      acc_rise[i] = ds[i] &&
                    ((state_q[i] == S_LOW && SINGLE) ||
                     (state_q[i] == S_RISE_PEND && cnt_q[i] == LAST));
      acc_fall[i] = !ds[i] &&
                    ((state_q[i] == S_HIGH && SINGLE) ||
                     (state_q[i] == S_FALL_PEND && cnt_q[i] == LAST));
      fire[i]     = (acc_rise[i] && bus.mode[2*i]) || (acc_fall[i] && bus.mode[2*i+1]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= S_LOW;
        cnt_q[i]   <= '0;
      end
      level_q  <= '0;
      pulse_q  <= '0;
      sticky_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        pulse_q[i] <= fire[i];
        if (fire[i]) begin
          sticky_q[i] <= 1'b1;
        end else if (bus.clr[i]) begin
          sticky_q[i] <= 1'b0;
        end

        case (state_q[i])
          S_LOW: begin
            if (acc_rise[i]) begin
              state_q[i] <= S_HIGH;
              level_q[i] <= 1'b1;
            end else if (ds[i]) begin
              state_q[i] <= S_RISE_PEND;
              cnt_q[i]   <= CNT_W'(1);
            end
          end
          S_RISE_PEND: begin
            if (!ds[i]) begin
              state_q[i] <= S_LOW;
              cnt_q[i]   <= '0;
            end else if (acc_rise[i]) begin
              state_q[i] <= S_HIGH;
              cnt_q[i]   <= '0;
              level_q[i] <= 1'b1;
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
          end
          S_HIGH: begin
            if (acc_fall[i]) begin
              state_q[i] <= S_LOW;
              level_q[i] <= 1'b0;
            end else if (!ds[i]) begin
              state_q[i] <= S_FALL_PEND;
              cnt_q[i]   <= CNT_W'(1);
            end
          end
          S_FALL_PEND: begin
            if (ds[i]) begin
              state_q[i] <= S_HIGH;
              cnt_q[i]   <= '0;
            end else if (acc_fall[i]) begin
              state_q[i] <= S_LOW;
              cnt_q[i]   <= '0;
              level_q[i] <= 1'b0;
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
          end
          default: begin
            state_q[i] <= S_LOW;
            cnt_q[i]   <= '0;
            level_q[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pulse  = pulse_q;
  assign bus.level  = level_q;
  assign bus.sticky = sticky_q;
  assign bus.irq    = |sticky_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench: a 4-channel synchronised/filtered instance and a 1-channel unfiltered instance.
module tb_edge_detect_multi;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  edge_detect_multi_if #(.CHANNELS(4)) bus_a ();
  edge_detect_multi_if #(.CHANNELS(1)) bus_b ();

  edge_detect_multi #(.CHANNELS(4), .SYNC_STAGES(2), .FILTER_LEN(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a)
  );

  edge_detect_multi #(.CHANNELS(1), .SYNC_STAGES(0), .FILTER_LEN(1)) dut_min (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_a.din = '0; bus_a.mode = 8'h55; bus_a.clr = '0;
    bus_b.din = 1'b0; bus_b.mode = 2'b11; bus_b.clr = 1'b0;
    repeat (3) tick();
    checks++; if (bus_a.pulse !== 4'b0)  begin errors++; $display("FAIL reset_pulse: got %b expected 0000", bus_a.pulse); end
    checks++; if (bus_a.level !== 4'b0)  begin errors++; $display("FAIL reset_level: got %b expected 0000", bus_a.level); end
    checks++; if (bus_a.sticky !== 4'b0) begin errors++; $display("FAIL reset_sticky: got %b expected 0000", bus_a.sticky); end
    checks++; if (bus_a.irq !== 1'b0)    begin errors++; $display("FAIL reset_irq: got %b expected 0", bus_a.irq); end
    checks++; if ({bus_b.pulse, bus_b.level} !== 2'b00) begin errors++; $display("FAIL reset_min: got %b expected 00", {bus_b.pulse, bus_b.level}); end
    reset = 1'b0;
  endtask

  task automatic test_basic_rise();
    logic [3:0] ep, el;
    bus_a.din = 4'b0001;
    for (int j = 1; j <= 9; j++) begin
      tick();
      ep = {3'b000, j == 5};
      el = {3'b000, j >= 5};
      checks++; if (bus_a.pulse !== ep)  begin errors++; $display("FAIL basic_pulse t=%0d: got %b expected %b", j, bus_a.pulse, ep); end
      checks++; if (bus_a.level !== el)  begin errors++; $display("FAIL basic_level t=%0d: got %b expected %b", j, bus_a.level, el); end
      checks++; if (bus_a.sticky !== el) begin errors++; $display("FAIL basic_sticky t=%0d: got %b expected %b", j, bus_a.sticky, el); end
      checks++; if (bus_a.irq !== el[0]) begin errors++; $display("FAIL basic_irq t=%0d: got %b expected %b", j, bus_a.irq, el[0]); end
    end
  endtask

  task automatic test_sticky_clear();
    bus_a.clr = 4'b0001; tick(); bus_a.clr = '0;
    checks++; if (bus_a.sticky !== 4'b0000) begin errors++; $display("FAIL clr_sticky: got %b expected 0000", bus_a.sticky); end
    checks++; if (bus_a.irq !== 1'b0)       begin errors++; $display("FAIL clr_irq: got %b expected 0", bus_a.irq); end
    bus_a.clr = 4'b0001; tick(); bus_a.clr = '0;
    checks++; if (bus_a.sticky !== 4'b0000) begin errors++; $display("FAIL clr_on_zero: got %b expected 0000", bus_a.sticky); end
    bus_a.din = 4'b0000;
    for (int j = 1; j <= 8; j++) begin
      tick();
      checks++; if (bus_a.pulse !== 4'b0000) begin errors++; $display("FAIL fall_nopulse t=%0d: got %b expected 0000", j, bus_a.pulse); end
    end
    checks++; if (bus_a.level !== 4'b0000) begin errors++; $display("FAIL fall_level: got %b expected 0000", bus_a.level); end
    bus_a.din = 4'b0001;
    repeat (4) tick();
    bus_a.clr = 4'b0001; tick(); bus_a.clr = '0;
    checks++; if (bus_a.pulse !== 4'b0001)  begin errors++; $display("FAIL setwins_pulse: got %b expected 0001", bus_a.pulse); end
    checks++; if (bus_a.sticky !== 4'b0001) begin errors++; $display("FAIL setwins_sticky: got %b expected 0001", bus_a.sticky); end
    tick();
    checks++; if (bus_a.sticky !== 4'b0001) begin errors++; $display("FAIL setwins_hold: got %b expected 0001", bus_a.sticky); end
    bus_a.clr = 4'b0001; tick(); bus_a.clr = '0;
    checks++; if ({bus_a.sticky, bus_a.irq} !== 5'b00000) begin errors++; $display("FAIL reclear: got %b expected 00000", {bus_a.sticky, bus_a.irq}); end
  endtask

  task automatic test_glitch();
    logic ep, el;
    bus_a.din[1] = 1'b1; tick(); tick(); bus_a.din[1] = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      tick();
      checks++; if ({bus_a.pulse[1], bus_a.level[1], bus_a.sticky[1]} !== 3'b000) begin
        errors++; $display("FAIL glitch2 t=%0d: got %b expected 000", j, {bus_a.pulse[1], bus_a.level[1], bus_a.sticky[1]});
      end
    end
    bus_a.din[1] = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (j == 3) bus_a.din[1] = 1'b0;
      ep = (j == 5);
      el = (j >= 5 && j <= 7);
      checks++; if (bus_a.pulse[1] !== ep) begin errors++; $display("FAIL glitch3_pulse t=%0d: got %b expected %b", j, bus_a.pulse[1], ep); end
      checks++; if (bus_a.level[1] !== el) begin errors++; $display("FAIL glitch3_level t=%0d: got %b expected %b", j, bus_a.level[1], el); end
    end
    checks++; if (bus_a.sticky[1] !== 1'b1) begin errors++; $display("FAIL glitch3_sticky: got %b expected 1", bus_a.sticky[1]); end
  endtask

  task automatic test_modes();
    logic w, er, ef, lv;
    logic [3:0] ep, el;
    bus_a.mode = 8'hE4;
    bus_a.din  = 4'b0000;
    for (int j = 1; j <= 8; j++) begin
      tick();
      checks++; if (bus_a.pulse !== 4'b0000) begin errors++; $display("FAIL mode_settle t=%0d: got %b expected 0000", j, bus_a.pulse); end
    end
    bus_a.clr = 4'hF; tick(); bus_a.clr = '0;
    for (int j = 1; j <= 40; j++) begin
      w = (((j - 1) / 8) % 2) == 0;
      bus_a.din = {w, w, 1'b0, w};
      tick();
      er = (j % 16) == 5;
      ef = (j % 16) == 13;
      lv = (j % 16) >= 5 && (j % 16) < 13;
      ep = {er | ef, ef, 1'b0, 1'b0};
      el = {lv, lv, 1'b0, lv};
      checks++; if (bus_a.pulse !== ep) begin errors++; $display("FAIL mode_pulse t=%0d: got %b expected %b", j, bus_a.pulse, ep); end
      checks++; if (bus_a.level !== el) begin errors++; $display("FAIL mode_level t=%0d: got %b expected %b", j, bus_a.level, el); end
    end
    checks++; if (bus_a.sticky !== 4'b1100) begin errors++; $display("FAIL mode_sticky: got %b expected 1100", bus_a.sticky); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ep, el;
    bus_a.din = 4'b1000;
    repeat (8) tick();
    bus_a.mode = 8'h55;
    bus_a.din  = 4'b1001;
    repeat (4) tick();
    checks++; if (bus_a.level !== 4'b1000)  begin errors++; $display("FAIL mid_pre_level: got %b expected 1000", bus_a.level); end
    checks++; if (bus_a.sticky !== 4'b1100) begin errors++; $display("FAIL mid_pre_sticky: got %b expected 1100", bus_a.sticky); end
    reset = 1'b1;
    #1;
    checks++; if ({bus_a.pulse, bus_a.level, bus_a.sticky, bus_a.irq} !== 13'b0) begin
      errors++; $display("FAIL mid_async: got %b expected all 0", {bus_a.pulse, bus_a.level, bus_a.sticky, bus_a.irq});
    end
    tick();
    reset = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      tick();
      ep = (j == 5) ? 4'b1001 : 4'b0000;
      el = (j >= 5) ? 4'b1001 : 4'b0000;
      checks++; if (bus_a.pulse !== ep) begin errors++; $display("FAIL mid_pulse t=%0d: got %b expected %b", j, bus_a.pulse, ep); end
      checks++; if (bus_a.level !== el) begin errors++; $display("FAIL mid_level t=%0d: got %b expected %b", j, bus_a.level, el); end
    end
  endtask

  task automatic test_degenerate();
    bus_b.din = 1'b1;
    tick();
    checks++; if ({bus_b.pulse, bus_b.level} !== 2'b11) begin errors++; $display("FAIL min_first: got %b expected 11", {bus_b.pulse, bus_b.level}); end
    tick();
    checks++; if ({bus_b.pulse, bus_b.level} !== 2'b01) begin errors++; $display("FAIL min_hold: got %b expected 01", {bus_b.pulse, bus_b.level}); end
    for (int j = 1; j <= 6; j++) begin
      bus_b.din = ~bus_b.din;
      tick();
      checks++; if ({bus_b.pulse, bus_b.level} !== {1'b1, bus_b.din}) begin
        errors++; $display("FAIL min_toggle t=%0d: got %b expected %b", j, {bus_b.pulse, bus_b.level}, {1'b1, bus_b.din});
      end
    end
    checks++; if (bus_b.sticky !== 1'b1) begin errors++; $display("FAIL min_sticky: got %b expected 1", bus_b.sticky); end
  endtask

  initial begin
    test_reset();
    test_basic_rise();
    test_sticky_clear();
    test_glitch();
    test_modes();
    test_reset_mid();
    test_degenerate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
